data_bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single 8-bit data channel feeding the data sink between NUM_REQ requesters. Each requester offers packets on a valid/ready/last handshake. The arbiter grants one requester at a time and holds the grant for the whole packet. It forwards that requester's beats to the shared output channel, which uses the same valid/ready/last handshake. It sits between the stimulus sources and the sink, in place of a direct data connection.

---
 rtl/data_bus_rr_arbiter_if.sv | 29 ++
 rtl/data_bus_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_data_bus_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_rr_arbiter_if.sv
// rtl/data_bus_rr_arbiter_if.sv - requester and shared-channel handshake bundle for data_bus_rr_arbiter
interface data_bus_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [NUM_REQ-1:0]        gnt;
  logic [ID_W-1:0]           gnt_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, gnt, gnt_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, gnt, gnt_id, busy
  );
endinterface

// File: rtl/data_bus_rr_arbiter.sv
// rtl/data_bus_rr_arbiter.sv - round-robin packet arbiter sharing one data channel among NUM_REQ requesters
// Define DATA_ARB_STATS_EN to add per-requester saturating packet counters on pkt_count.
module data_bus_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_rr_arbiter_if.slave bus
`ifdef DATA_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] pkt_count
`endif
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_gnt_id;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_busy;

  logic                w_pick_found;
  logic [ID_W-1:0]     w_pick_id;
  logic [ID_W-1:0]     w_ptr_next;
  logic                w_out_valid;
  logic [DATA_W-1:0]   w_out_data;
  logic                w_out_last;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_xfer_last;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin : pick
    int idx;
    idx          = 0;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_pick_found && bus.req_valid[idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_out_last  = 1'b0;
    w_req_ready = '0;
    if (r_state == S_BUSY) begin
      w_out_valid           = bus.req_valid[r_gnt_id];
      w_out_data            = bus.req_data[int'(r_gnt_id)*DATA_W +: DATA_W];
      w_out_last            = bus.req_last[r_gnt_id];
      w_req_ready[r_gnt_id] = bus.out_ready;
    end
  end

  assign w_xfer_last = (r_state == S_BUSY) && w_out_valid && bus.out_ready && w_out_last;
  assign w_ptr_next  = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_found) w_next_state = S_BUSY;
      S_BUSY:  if (w_xfer_last)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= '0;
    end else if (r_state == S_IDLE && w_pick_found) begin
      r_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_id;
      r_gnt_id <= w_pick_id;
      r_busy   <= 1'b1;
    end else if (w_xfer_last) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= w_ptr_next;
    end
  end

`ifdef DATA_ARB_STATS_EN
  logic [15:0] r_pkt_count [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_pkt_count[i] <= '0;
    end else if (w_xfer_last && r_pkt_count[r_gnt_id] != 16'hFFFF) begin
      r_pkt_count[r_gnt_id] <= r_pkt_count[r_gnt_id] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign pkt_count[gi*16 +: 16] = r_pkt_count[gi];
  end
`endif

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_last  = w_out_last;
  assign bus.req_ready = w_req_ready;
  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_data_bus_rr_arbiter.sv
// tb/tb_data_bus_rr_arbiter.sv - self-checking bench for data_bus_rr_arbiter
module tb_data_bus_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_bus_rr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();
`ifdef DATA_ARB_STATS_EN
  logic [NR*16-1:0] pkt_count;
`endif

  data_bus_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DATA_ARB_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester pending beats as {last, data}; transfer log as {gnt_id, last, data}.
  logic [8:0]  src_q [NR][$];
  logic [10:0] log_q [$];
  logic [10:0] exp_q [$];
  logic [NR-1:0] hold_off;
  logic rdy_drive;

  logic [NR-1:0] o_gnt, o_req_ready;
  logic [1:0]    o_gnt_id;
  logic          o_busy, o_valid, o_last;
  logic [7:0]    o_data;

  function automatic bit any_pending();
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    log_q.delete();
    hold_off = '0;
    rdy_drive = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive requesters from their queues, observe, retire handshaken beats.
  task automatic step();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        d[i*DW +: DW] = src_q[i][0][7:0];
        l[i]          = src_q[i][0][8];
        v[i]          = !hold_off[i];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.out_ready = rdy_drive;
    #1;
    o_gnt = bus.gnt; o_gnt_id = bus.gnt_id; o_busy = bus.busy;
    o_valid = bus.out_valid; o_data = bus.out_data; o_last = bus.out_last;
    o_req_ready = bus.req_ready;
    if (bus.out_valid && bus.out_ready) log_q.push_back({bus.gnt_id, bus.out_last, bus.out_data});
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
  endtask

  task automatic drain(output bit timed_out);
    int c = 0;
    while (any_pending() && c < 500) begin step(); c++; end
    step(); step();
    timed_out = (c >= 500);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1; bus.req_data = '1; bus.req_last = '1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %h expected 0", bus.gnt); end
    n_checks++; if (bus.gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %h expected 0", bus.gnt_id); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %h expected 0", bus.req_ready); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
    do_reset();
    for (int b = 0; b < 3; b++) src_q[0].push_back({b == 2, exp_b[b]});
    step();
    n_checks++; if (o_gnt !== 4'b0000) begin n_fail++; $display("FAIL tp1_latency_gnt: got %h expected 0", o_gnt); end
    for (int b = 0; b < 3; b++) begin
      step();
      n_checks++; if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL tp1_gnt beat %0d: got %h expected 1", b, o_gnt); end
      n_checks++; if (o_valid !== 1'b1 || o_data !== exp_b[b]) begin n_fail++; $display("FAIL tp1_data beat %0d: got v=%b %h expected v=1 %h", b, o_valid, o_data, exp_b[b]); end
      n_checks++; if (o_last !== (b == 2)) begin n_fail++; $display("FAIL tp1_last beat %0d: got %b expected %b", b, o_last, b == 2); end
    end
    step();
    n_checks++; if (o_busy !== 1'b0 || o_gnt !== 4'b0) begin n_fail++; $display("FAIL tp1_bubble: got busy=%b gnt=%h expected busy=0 gnt=0", o_busy, o_gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < NR; i++) repeat (2) src_q[i].push_back({1'b1, 8'($urandom)});
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (o_busy !== 1'b0 || o_gnt !== 4'b0 || o_gnt_id !== 2'd0) begin n_fail++; $display("FAIL tp2_bubble %0d: got busy=%b gnt=%h id=%0d expected 0 0 0", k, o_busy, o_gnt, o_gnt_id); end
      step();
      e = 4'b0001 << (k % 4);
      n_checks++; if (o_gnt !== e || o_gnt_id !== 2'(k % 4)) begin n_fail++; $display("FAIL tp2_grant %0d: got gnt=%h id=%0d expected gnt=%h id=%0d", k, o_gnt, o_gnt_id, e, k % 4); end
      n_checks++; if (o_valid !== 1'b1 || o_last !== 1'b1) begin n_fail++; $display("FAIL tp2_beat %0d: got v=%b l=%b expected 1 1", k, o_valid, o_last); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_q[2].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b1, 8'h22});
    step();
    step();
    n_checks++; if (o_data !== 8'h11 || o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL tp3_first: got %h rdy=%h expected 11 rdy=4", o_data, o_req_ready); end
    rdy_drive = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++; if (o_valid !== 1'b1 || o_data !== 8'h22 || o_last !== 1'b1) begin n_fail++; $display("FAIL tp3_hold %0d: got v=%b %h l=%b expected v=1 22 l=1", c, o_valid, o_data, o_last); end
      n_checks++; if (o_req_ready[2] !== 1'b0) begin n_fail++; $display("FAIL tp3_ready %0d: got %b expected 0", c, o_req_ready[2]); end
    end
    rdy_drive = 1'b1;
    step();
    n_checks++; if (o_data !== 8'h22 || o_req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL tp3_release: got %h rdy=%b expected 22 rdy=1", o_data, o_req_ready[2]); end
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL tp3_done_busy: got %b expected 0", o_busy); end
    n_checks++; if (log_q.size() != 2 || log_q[0][7:0] !== 8'h11 || log_q[1][7:0] !== 8'h22) begin n_fail++; $display("FAIL tp3_beats: got %0d beats expected 2 (11,22)", log_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    do_reset();
    src_q[2].push_back({1'b1, 8'h42});
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL tp4_drain: got timeout expected completion"); end
    for (int b = 0; b < 3; b++) src_q[1].push_back({b == 2, 8'(8'h60 + b)});
    step(); step();
    n_checks++; if (o_busy !== 1'b1 || o_gnt !== 4'b0010) begin n_fail++; $display("FAIL tp4_pre: got busy=%b gnt=%h expected 1 2", o_busy, o_gnt); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 4'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL tp4_async: got gnt=%h v=%b busy=%b expected 0 0 0", bus.gnt, bus.out_valid, bus.busy); end
    do_reset();
    src_q[1].push_back({1'b1, 8'h01});
    src_q[3].push_back({1'b1, 8'h03});
    step();
    step();
    n_checks++; if (o_gnt !== 4'b0010 || o_gnt_id !== 2'd1) begin n_fail++; $display("FAIL tp4_restart: got gnt=%h id=%0d expected 2 id=1", o_gnt, o_gnt_id); end
  endtask

  task automatic test_valid_gap();
    do_reset();
    src_q[0].push_back({1'b0, 8'h10});
    src_q[0].push_back({1'b0, 8'h20});
    src_q[0].push_back({1'b1, 8'h30});
    src_q[1].push_back({1'b1, 8'h77});
    step(); step();
    hold_off[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (o_gnt !== 4'b0001 || o_valid !== 1'b0 || o_req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL tp5_gap %0d: got gnt=%h v=%b rdy1=%b expected 1 0 0", c, o_gnt, o_valid, o_req_ready[1]); end
    end
    hold_off[0] = 1'b0;
    step();
    n_checks++; if (o_data !== 8'h20 || o_gnt !== 4'b0001) begin n_fail++; $display("FAIL tp5_resume: got %h gnt=%h expected 20 gnt=1", o_data, o_gnt); end
    step();
    n_checks++; if (o_data !== 8'h30 || o_last !== 1'b1) begin n_fail++; $display("FAIL tp5_last: got %h l=%b expected 30 l=1", o_data, o_last); end
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL tp5_bubble: got busy=%b expected 0", o_busy); end
    step();
    n_checks++; if (o_gnt !== 4'b0010 || o_data !== 8'h77) begin n_fail++; $display("FAIL tp5_next: got gnt=%h %h expected 2 77", o_gnt, o_data); end
  endtask

  // Packet-level model: all packets are queued up front, so the output order is
  // fully determined by the round-robin rule regardless of sink backpressure.
  task automatic test_random_traffic();
    logic [8:0] mq [NR][$];
    logic [8:0] beat;
    int ptr, pick, cyc, len, npk;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      npk = $urandom_range(0, 4);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
      end
    end
    for (int i = 0; i < NR; i++) mq[i] = src_q[i];
    exp_q.delete();
    ptr = 0;
    forever begin
      pick = -1;
      for (int k = 0; k < NR; k++)
        if (pick < 0 && mq[(ptr + k) % NR].size() > 0) pick = (ptr + k) % NR;
      if (pick < 0) break;
      do begin
        beat = mq[pick].pop_front();
        exp_q.push_back({2'(pick), beat});
      end while (!beat[8]);
      ptr = (pick + 1) % NR;
    end
    cyc = 0;
    while (log_q.size() < exp_q.size() && cyc < 3000) begin
      rdy_drive = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
      n_checks++;
      if (o_busy ? (o_gnt !== (4'b0001 << o_gnt_id)) : (o_gnt !== 4'b0 || o_data !== 8'h00 || o_valid !== 1'b0)) begin
        n_fail++; $display("FAIL rnd_consistency cyc %0d: got busy=%b gnt=%h id=%0d data=%h", cyc, o_busy, o_gnt, o_gnt_id, o_data);
      end
    end
    n_checks++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d beats expected %0d", log_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      n_checks++; if (log_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rnd_beat %0d: got %h expected %h", j, log_q[j], exp_q[j]); end
    end
  endtask

`ifdef DATA_ARB_STATS_EN
  task automatic test_stats();
    bit to;
    do_reset();
    repeat (5) src_q[3].push_back({1'b1, 8'h5A});
    drain(to);
    n_checks++; if (to || pkt_count[63:48] !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %h expected 0005", pkt_count[63:48]); end
    n_checks++; if (pkt_count[47:0] !== 48'd0) begin n_fail++; $display("FAIL stats_others: got %h expected 0", pkt_count[47:0]); end
    dut.r_pkt_count[3] = 16'hFFFE;
    repeat (3) src_q[3].push_back({1'b1, 8'hA5});
    drain(to);
    n_checks++; if (to || pkt_count[63:48] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate: got %h expected FFFF", pkt_count[63:48]); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
    test_valid_gap();
    repeat (8) test_random_traffic();
`ifdef DATA_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
